icache_refill_ctrl: RTL and testbench

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

---
 rtl/icache_refill_ctrl_pkg.sv | 32 +++
 rtl/icache_refill_ctrl_buf.sv | 39 +++
 rtl/icache_refill_ctrl.sv | 163 ++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared widths, FSM encoding and address-field helpers for the icache refill controller.
package icache_refill_ctrl_pkg;

  localparam int PHY_ADDR_WIDTH    = 34;
  localparam int ICACHE_TAG_WIDTH  = 20;
  localparam int ICACHE_IDX_WIDTH  = 8;
  localparam int ICACHE_DATA_WIDTH = 512;
  localparam int ICACHE_BEATS      = 8;
  localparam int LINE_OFFSET_WIDTH = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_MISS_REQ = 3'd2,
    ST_REFILL   = 3'd3,
    ST_WRITE    = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  function automatic logic [ICACHE_TAG_WIDTH-1:0] line_tag(input logic [PHY_ADDR_WIDTH-1:0] paddr);
    return paddr[PHY_ADDR_WIDTH-1 -: ICACHE_TAG_WIDTH];
  endfunction

  function automatic logic [ICACHE_IDX_WIDTH-1:0] line_idx(input logic [PHY_ADDR_WIDTH-1:0] paddr);
    return paddr[LINE_OFFSET_WIDTH +: ICACHE_IDX_WIDTH];
  endfunction

  function automatic logic [PHY_ADDR_WIDTH-1:0] line_base(input logic [PHY_ADDR_WIDTH-1:0] paddr);
    return {paddr[PHY_ADDR_WIDTH-1:LINE_OFFSET_WIDTH], LINE_OFFSET_WIDTH'(0)};
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_buf.sv
// Beat counter and line assembly buffer for a cache-line refill.
module icache_refill_buf #(
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 8,
  parameter int LINE_WIDTH = BEAT_WIDTH * BEATS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  beat_vld,
  input  logic [BEAT_WIDTH-1:0] beat_dat,
  output logic [LINE_WIDTH-1:0] line,
  output logic                  last
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0] cnt;

  assign last = beat_vld && (cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (beat_vld) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

  // NOTE: the line buffer is pure datapath and is always fully rewritten before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (beat_vld) begin
      line[int'(cnt) * BEAT_WIDTH +: BEAT_WIDTH] <= beat_dat;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache fetch controller: lookup, miss request, line refill, cache write and response.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = ICACHE_DATA_WIDTH / BEAT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_fetch_req,
  output logic                         o_fetch_rdy,
  input  logic [PHY_ADDR_WIDTH-1:0]    i_fetch_paddr,
  input  logic                         i_fetch_kill,
  output logic                         o_fetch_vld,
  input  logic                         i_fetch_rsp_rdy,
  output logic [ICACHE_DATA_WIDTH-1:0] o_fetch_dat,
  output logic                         o_icache_req,
  output logic [ICACHE_TAG_WIDTH-1:0]  o_icache_rtag,
  output logic [ICACHE_IDX_WIDTH-1:0]  o_icache_ridx,
  input  logic                         i_icache_hit,
  input  logic [ICACHE_DATA_WIDTH-1:0] i_icache_rdat,
  output logic                         o_icache_wren,
  output logic [ICACHE_IDX_WIDTH-1:0]  o_icache_widx,
  output logic [ICACHE_TAG_WIDTH-1:0]  o_icache_wtag,
  output logic [ICACHE_DATA_WIDTH-1:0] o_icache_wdat,
  input  logic                         i_inv_vld,
  input  logic [PHY_ADDR_WIDTH-1:0]    i_inv_paddr,
  output logic                         o_inv_rdy,
  output logic                         o_icache_inv_vld,
  output logic [PHY_ADDR_WIDTH-1:0]    o_icache_inv_paddr,
  output logic                         o_mem_req,
  output logic [PHY_ADDR_WIDTH-1:0]    o_mem_paddr,
  input  logic                         i_mem_gnt,
  input  logic                         i_mem_rvld,
  input  logic [BEAT_WIDTH-1:0]        i_mem_rdat
);

  state_e                       state;
  logic                         drop;
  logic                         fetch_vld;
  logic                         icache_req;
  logic                         mem_req;
  logic                         wren;
  logic                         inv_vld;
  logic [PHY_ADDR_WIDTH-1:0]    paddr_q;
  logic [PHY_ADDR_WIDTH-1:0]    inv_paddr_q;
  logic [ICACHE_DATA_WIDTH-1:0] dat_q;
  logic [ICACHE_DATA_WIDTH-1:0] line;
  logic                         beat_last;
  logic                         fetch_acc;
  logic                         inv_acc;

  assign o_inv_rdy   = (state == ST_IDLE);
  assign o_fetch_rdy = (state == ST_IDLE) && !i_inv_vld;
  assign fetch_acc   = o_fetch_rdy && i_fetch_req;
  assign inv_acc     = o_inv_rdy && i_inv_vld;

  icache_refill_buf #(
    .BEAT_WIDTH(BEAT_WIDTH),
    .BEATS     (BEATS)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state == ST_MISS_REQ) && i_mem_gnt),
    .beat_vld((state == ST_REFILL) && i_mem_rvld),
    .beat_dat(i_mem_rdat),
    .line    (line),
    .last    (beat_last)
  );

  // A kill that arrives once memory has granted cannot stop the beats, so it is recorded in drop
  // and only the response is suppressed; the line is still written into the cache.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      drop       <= 1'b0;
      fetch_vld  <= 1'b0;
      icache_req <= 1'b0;
      mem_req    <= 1'b0;
      wren       <= 1'b0;
      inv_vld    <= 1'b0;
    end else begin
      inv_vld <= inv_acc;
      wren    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (fetch_acc) begin
            state      <= ST_LOOKUP;
            icache_req <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          icache_req <= 1'b0;
          if (i_fetch_kill) begin
            state <= ST_IDLE;
          end else if (i_icache_hit) begin
            state     <= ST_RESP;
            fetch_vld <= 1'b1;
          end else begin
            state   <= ST_MISS_REQ;
            mem_req <= 1'b1;
          end
        end
        ST_MISS_REQ: begin
          if (i_mem_gnt) begin
            state   <= ST_REFILL;
            mem_req <= 1'b0;
            drop    <= i_fetch_kill;
          end else if (i_fetch_kill) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
          end
        end
        ST_REFILL: begin
          if (i_fetch_kill) drop <= 1'b1;
          if (beat_last) begin
            state <= ST_WRITE;
            wren  <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (drop || i_fetch_kill) begin
            state <= ST_IDLE;
            drop  <= 1'b0;
          end else begin
            state     <= ST_RESP;
            fetch_vld <= 1'b1;
          end
        end
        ST_RESP: begin
          if (i_fetch_kill || i_fetch_rsp_rdy) begin
            state     <= ST_IDLE;
            fetch_vld <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fetch_acc) paddr_q <= i_fetch_paddr;
    if (inv_acc) inv_paddr_q <= i_inv_paddr;
    if (state == ST_LOOKUP && i_icache_hit) dat_q <= i_icache_rdat;
    else if (state == ST_WRITE) dat_q <= line;
  end

  // Address and data outputs are forced to zero whenever their qualifier is low.
  assign o_fetch_vld        = fetch_vld;
  assign o_fetch_dat        = fetch_vld ? dat_q : '0;
  assign o_icache_req       = icache_req;
  assign o_icache_rtag      = icache_req ? line_tag(paddr_q) : '0;
  assign o_icache_ridx      = icache_req ? line_idx(paddr_q) : '0;
  assign o_icache_wren      = wren;
  assign o_icache_widx      = wren ? line_idx(paddr_q) : '0;
  assign o_icache_wtag      = wren ? line_tag(paddr_q) : '0;
  assign o_icache_wdat      = wren ? line : '0;
  assign o_icache_inv_vld   = inv_vld;
  assign o_icache_inv_paddr = inv_vld ? inv_paddr_q : '0;
  assign o_mem_req          = mem_req;
  assign o_mem_paddr        = mem_req ? line_base(paddr_q) : '0;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: table-driven lookups plus hand-written refill, kill, invalidate and reset sequences.
module tb_icache_refill_ctrl;
  import icache_refill_ctrl_pkg::*;

  localparam int BW = 64;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         fetch_req = 1'b0;
  logic                         fetch_rdy;
  logic [PHY_ADDR_WIDTH-1:0]    fetch_paddr = '0;
  logic                         fetch_kill = 1'b0;
  logic                         fetch_vld;
  logic                         fetch_rsp_rdy = 1'b0;
  logic [ICACHE_DATA_WIDTH-1:0] fetch_dat;
  logic                         icache_req;
  logic [ICACHE_TAG_WIDTH-1:0]  icache_rtag;
  logic [ICACHE_IDX_WIDTH-1:0]  icache_ridx;
  logic                         icache_hit = 1'b0;
  logic [ICACHE_DATA_WIDTH-1:0] icache_rdat = '0;
  logic                         icache_wren;
  logic [ICACHE_IDX_WIDTH-1:0]  icache_widx;
  logic [ICACHE_TAG_WIDTH-1:0]  icache_wtag;
  logic [ICACHE_DATA_WIDTH-1:0] icache_wdat;
  logic                         inv_vld = 1'b0;
  logic [PHY_ADDR_WIDTH-1:0]    inv_paddr = '0;
  logic                         inv_rdy;
  logic                         icache_inv_vld;
  logic [PHY_ADDR_WIDTH-1:0]    icache_inv_paddr;
  logic                         mem_req;
  logic [PHY_ADDR_WIDTH-1:0]    mem_paddr;
  logic                         mem_gnt = 1'b0;
  logic                         mem_rvld = 1'b0;
  logic [BW-1:0]                mem_rdat = '0;

  always #5 clk = ~clk;

  icache_refill_ctrl #(.BEAT_WIDTH(BW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_fetch_req       (fetch_req),
    .o_fetch_rdy       (fetch_rdy),
    .i_fetch_paddr     (fetch_paddr),
    .i_fetch_kill      (fetch_kill),
    .o_fetch_vld       (fetch_vld),
    .i_fetch_rsp_rdy   (fetch_rsp_rdy),
    .o_fetch_dat       (fetch_dat),
    .o_icache_req      (icache_req),
    .o_icache_rtag     (icache_rtag),
    .o_icache_ridx     (icache_ridx),
    .i_icache_hit      (icache_hit),
    .i_icache_rdat     (icache_rdat),
    .o_icache_wren     (icache_wren),
    .o_icache_widx     (icache_widx),
    .o_icache_wtag     (icache_wtag),
    .o_icache_wdat     (icache_wdat),
    .i_inv_vld         (inv_vld),
    .i_inv_paddr       (inv_paddr),
    .o_inv_rdy         (inv_rdy),
    .o_icache_inv_vld  (icache_inv_vld),
    .o_icache_inv_paddr(icache_inv_paddr),
    .o_mem_req         (mem_req),
    .o_mem_paddr       (mem_paddr),
    .i_mem_gnt         (mem_gnt),
    .i_mem_rvld        (mem_rvld),
    .i_mem_rdat        (mem_rdat)
  );

  int checks = 0;
  int failures = 0;
  int wren_cnt = 0;
  int vld_cnt = 0;

  // Running pulse counters sampled mid-cycle; sequences compare deltas.
  always @(negedge clk) begin
    if (icache_wren) wren_cnt++;
    if (fetch_vld) vld_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [PHY_ADDR_WIDTH-1:0]    paddr;
    logic                         hit;
    logic [ICACHE_DATA_WIDTH-1:0] rdat;
    logic [ICACHE_TAG_WIDTH-1:0]  exp_tag;
    logic [ICACHE_IDX_WIDTH-1:0]  exp_idx;
    logic [PHY_ADDR_WIDTH-1:0]    exp_mem_paddr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [ICACHE_DATA_WIDTH-1:0] act,
                       input logic [ICACHE_DATA_WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [ICACHE_DATA_WIDTH-1:0] beat_line(input logic [7:0] base, input bit step11);
    logic [ICACHE_DATA_WIDTH-1:0] l;
    l = '0;
    for (int k = 0; k < ICACHE_BEATS; k++) begin
      if (step11) l[k*BW +: BW] = 64'(8'h11 * (k + 1));
      else l[k*BW +: BW] = {8{8'(base + 8'(k))}};
    end
    return l;
  endfunction

  // Accept a fetch in IDLE and answer the lookup with a miss; leaves the bench in the MISS_REQ cycle.
  task automatic fetch_to_miss(input logic [PHY_ADDR_WIDTH-1:0] pa);
    fetch_req = 1'b1;
    fetch_paddr = pa;
    tick();
    fetch_req = 1'b0;
    icache_hit = 1'b0;
    tick();
  endtask

  // Full miss with immediate grant and back-to-back beats, then checks of write and response.
  task automatic run_miss(input string tag, input logic [PHY_ADDR_WIDTH-1:0] pa, input logic [7:0] base);
    logic [ICACHE_DATA_WIDTH-1:0] exp_line;
    exp_line = beat_line(base, 1'b0);
    fetch_to_miss(pa);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int k = 0; k < ICACHE_BEATS; k++) begin
      mem_rvld = 1'b1;
      mem_rdat = {8{8'(base + 8'(k))}};
      tick();
    end
    mem_rvld = 1'b0;
    mem_rdat = '0;
    settle();
    check({tag, " wren"}, icache_wren, 1);
    check({tag, " wdat"}, icache_wdat, exp_line);
    tick();
    fetch_rsp_rdy = 1'b1;
    settle();
    check({tag, " vld"}, fetch_vld, 1);
    check({tag, " dat"}, fetch_dat, exp_line);
    tick();
    fetch_rsp_rdy = 1'b0;
  endtask

  initial begin
    int w0, v0;
    logic [ICACHE_DATA_WIDTH-1:0] miss_line;

    vecs[0] = '{34'h0_0000_1040, 1'b1, {16{32'hDEAD_0001}}, 20'h00000, 8'h41, 34'h0};
    vecs[1] = '{34'h1_2345_6789, 1'b1, {8{64'h0123_4567_89AB_CDEF}}, 20'h48D15, 8'h9E, 34'h0};
    vecs[2] = '{34'h3_FFFF_C07F, 1'b0, '0, 20'hFFFFF, 8'h01, 34'h3_FFFF_C040};
    vecs[3] = '{34'h0_ABCD_EFFF, 1'b0, '0, 20'h2AF37, 8'hBF, 34'h0_ABCD_EFC0};

    // Reset state
    tick();
    tick();
    check("rst fetch_vld", fetch_vld, 0);
    check("rst mem_req", mem_req, 0);
    check("rst wren", icache_wren, 0);
    check("rst icache_req", icache_req, 0);
    check("rst inv_vld", icache_inv_vld, 0);
    check("rst fetch_rdy", fetch_rdy, 1);
    rst_n = 1'b1;
    tick();

    // Table: lookup fields, hit latency/data, miss address alignment and kill before grant
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1;
      fetch_paddr = vecs[i].paddr;
      settle();
      check($sformatf("v%0d accept rdy", i), fetch_rdy, 1);
      tick();
      fetch_req = 1'b0;
      icache_hit = vecs[i].hit;
      icache_rdat = vecs[i].rdat;
      settle();
      check($sformatf("v%0d icache_req", i), icache_req, 1);
      check($sformatf("v%0d rtag", i), icache_rtag, vecs[i].exp_tag);
      check($sformatf("v%0d ridx", i), icache_ridx, vecs[i].exp_idx);
      tick();
      icache_hit = 1'b0;
      icache_rdat = '0;
      if (vecs[i].hit) begin
        fetch_rsp_rdy = 1'b1;
        settle();
        check($sformatf("v%0d vld at T+2", i), fetch_vld, 1);
        check($sformatf("v%0d dat", i), fetch_dat, vecs[i].rdat);
        check($sformatf("v%0d no mem_req", i), mem_req, 0);
        tick();
        fetch_rsp_rdy = 1'b0;
        settle();
        check($sformatf("v%0d vld drop", i), fetch_vld, 0);
        check($sformatf("v%0d idle rdy", i), fetch_rdy, 1);
      end else begin
        fetch_kill = 1'b1;
        settle();
        check($sformatf("v%0d mem_req", i), mem_req, 1);
        check($sformatf("v%0d mem_paddr", i), mem_paddr, vecs[i].exp_mem_paddr);
        tick();
        fetch_kill = 1'b0;
        settle();
        check($sformatf("v%0d killed mem_req", i), mem_req, 0);
        check($sformatf("v%0d killed mem_paddr", i), mem_paddr, 0);
        check($sformatf("v%0d killed rdy", i), fetch_rdy, 1);
      end
      tick();
    end

    // Miss with delayed grant, gapped beats, then response back-pressure
    w0 = wren_cnt;
    miss_line = beat_line(8'h0, 1'b1);
    fetch_to_miss(34'h3_FFFF_C07F);
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("miss wait%0d mem_paddr", c), mem_paddr, 34'h3_FFFF_C040);
      tick();
    end
    mem_gnt = 1'b1;
    settle();
    check("miss gnt mem_req", mem_req, 1);
    tick();
    mem_gnt = 1'b0;
    settle();
    check("refill mem_req low", mem_req, 0);
    for (int k = 0; k < ICACHE_BEATS; k++) begin
      mem_rvld = 1'b1;
      mem_rdat = 64'(8'h11 * (k + 1));
      tick();
      mem_rvld = 1'b0;
      mem_rdat = '0;
      if (k < ICACHE_BEATS - 1) tick();
    end
    settle();
    check("miss wren", icache_wren, 1);
    check("miss widx", icache_widx, 8'h01);
    check("miss wtag", icache_wtag, 20'hFFFFF);
    check("miss beat0", icache_wdat[63:0], 64'h11);
    check("miss wdat", icache_wdat, miss_line);
    tick();
    for (int c = 0; c < 5; c++) begin
      settle();
      check($sformatf("bp%0d vld", c), fetch_vld, 1);
      check($sformatf("bp%0d dat", c), fetch_dat, miss_line);
      tick();
    end
    fetch_rsp_rdy = 1'b1;
    settle();
    check("bp accept vld", fetch_vld, 1);
    tick();
    fetch_rsp_rdy = 1'b0;
    settle();
    check("bp after vld", fetch_vld, 0);
    check("bp after rdy", fetch_rdy, 1);
    check("miss one wren", wren_cnt - w0, 1);

    // Kill during REFILL after beat 3
    w0 = wren_cnt;
    v0 = vld_cnt;
    fetch_to_miss(34'h0_ABCD_EFFF);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int k = 0; k < ICACHE_BEATS; k++) begin
      if (k == 4) begin
        mem_rvld = 1'b0;
        fetch_kill = 1'b1;
        tick();
        fetch_kill = 1'b0;
      end
      mem_rvld = 1'b1;
      mem_rdat = {8{8'(8'hA0 + 8'(k))}};
      tick();
    end
    mem_rvld = 1'b0;
    settle();
    check("kill refill wren", icache_wren, 1);
    check("kill refill wdat", icache_wdat, beat_line(8'hA0, 1'b0));
    for (int c = 0; c < 4; c++) tick();
    check("kill refill wren count", wren_cnt - w0, 1);
    check("kill refill no vld", vld_cnt - v0, 0);
    check("kill refill rdy", fetch_rdy, 1);

    // Kill while holding a response
    fetch_req = 1'b1;
    fetch_paddr = 34'h0_0000_1040;
    tick();
    fetch_req = 1'b0;
    icache_hit = 1'b1;
    tick();
    icache_hit = 1'b0;
    fetch_kill = 1'b1;
    settle();
    check("resp kill vld before", fetch_vld, 1);
    tick();
    fetch_kill = 1'b0;
    settle();
    check("resp kill vld after", fetch_vld, 0);
    check("resp kill rdy", fetch_rdy, 1);
    tick();

    // Invalidate and fetch together; then kill a hitting lookup
    inv_vld = 1'b1;
    inv_paddr = 34'h2_468A_CEC0;
    fetch_req = 1'b1;
    fetch_paddr = 34'h0_0000_1040;
    settle();
    check("inv fetch_rdy blocked", fetch_rdy, 0);
    check("inv inv_rdy", inv_rdy, 1);
    tick();
    inv_vld = 1'b0;
    settle();
    check("inv fwd vld", icache_inv_vld, 1);
    check("inv fwd paddr", icache_inv_paddr, 34'h2_468A_CEC0);
    check("inv then fetch_rdy", fetch_rdy, 1);
    check("inv no lookup yet", icache_req, 0);
    tick();
    fetch_req = 1'b0;
    icache_hit = 1'b1;
    fetch_kill = 1'b1;
    settle();
    check("inv pulse end", icache_inv_vld, 0);
    check("fetch accepted late", icache_req, 1);
    tick();
    icache_hit = 1'b0;
    fetch_kill = 1'b0;
    settle();
    check("lookup kill no vld", fetch_vld, 0);
    check("lookup kill rdy", fetch_rdy, 1);
    tick();

    // Reset mid-REFILL, stray beats afterwards, then a clean refill
    w0 = wren_cnt;
    fetch_to_miss(34'h3_FFFF_C07F);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rvld = 1'b1;
      mem_rdat = 64'hFFFF_0000_0000_0000 | 64'(k);
      tick();
    end
    mem_rvld = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_rvld = 1'b1;
      mem_rdat = 64'hBAD0_0000_0000_0000 | 64'(k);
      tick();
    end
    mem_rvld = 1'b0;
    mem_rdat = '0;
    settle();
    check("rst refill no wren", wren_cnt - w0, 0);
    check("rst refill rdy", fetch_rdy, 1);
    check("rst refill mem_req", mem_req, 0);
    check("rst refill mem_paddr", mem_paddr, 0);
    check("rst refill vld", fetch_vld, 0);
    check("rst refill wdat", icache_wdat, 0);
    check("rst refill icache_req", icache_req, 0);
    run_miss("post rst miss", 34'h1_0000_0080, 8'h30);
    settle();
    check("final idle rdy", fetch_rdy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
